// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:2 nibble demux.
package demux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PART  = 2'd1,
    FULL  = 2'd2
  } demux_state_t;

  localparam logic MODE_ALT = 1'b0;
  localparam logic MODE_SEL = 1'b1;

endpackage

// File: rtl/module_slot_reg.sv
// Load-enabled holding register with synchronous reset to zero.
module module_slot_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/module_demux_12_seq.sv
// Steers a time-shared operand stream into two slot registers and presents them as one pair.
module module_demux_12_seq
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel_mode,
  input  logic             sel,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2,
  output logic             out_valid,
  input  logic             out_ack,
  output logic [CNT_W-1:0] pair_count
);

  demux_state_t     state_q, state_d;
  logic             w1_q, w1_d;
  logic             w2_q, w2_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             beat;
  logic             eff_mode;
  logic             to_slot2;
  logic             load_1, load_2;

  assign in_ready = !rst && (state_q != FULL);
  assign beat     = in_valid && in_ready;

  // Mode comes live from the port only on the beat that opens a pair; afterwards it is held.
  assign eff_mode = (state_q == EMPTY) ? sel_mode : mode_q;
  assign to_slot2 = (eff_mode == MODE_SEL) ? sel : (state_q == PART);

  always_comb begin
    state_d = state_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    load_1  = 1'b0;
    load_2  = 1'b0;
    unique case (state_q)
      EMPTY, PART: begin
        if (beat) begin
          if (state_q == EMPTY) begin
            mode_d = sel_mode;
          end
          if (to_slot2) begin
            load_2 = 1'b1;
            w2_d   = 1'b1;
          end else begin
            load_1 = 1'b1;
            w1_d   = 1'b1;
          end
          // Pair completes only when the other slot already holds data; same slot overwrites.
          state_d = (to_slot2 ? w1_q : w2_q) ? FULL : PART;
        end
      end
      FULL: begin
        if (out_ack) begin
          state_d = EMPTY;
          w1_d    = 1'b0;
          w2_d    = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = EMPTY;
        w1_d    = 1'b0;
        w2_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      w1_q    <= 1'b0;
      w2_q    <= 1'b0;
      mode_q  <= MODE_ALT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  module_slot_reg #(
    .WIDTH(WIDTH)
  ) u_slot_1 (
    .clk  (clk),
    .rst  (rst),
    .load (load_1),
    .d    (in_data),
    .q    (out_1)
  );

  module_slot_reg #(
    .WIDTH(WIDTH)
  ) u_slot_2 (
    .clk  (clk),
    .rst  (rst),
    .load (load_2),
    .d    (in_data),
    .q    (out_2)
  );

  assign out_valid  = (state_q == FULL);
  assign pair_count = cnt_q;

endmodule

// File: tb/tb_module_demux_12_seq.sv
// Directed self-checking bench for module_demux_12_seq.
module tb_module_demux_12_seq;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             sel_mode;
  logic             sel;
  logic [WIDTH-1:0] out_1;
  logic [WIDTH-1:0] out_2;
  logic             out_valid;
  logic             out_ack;
  logic [CNT_W-1:0] pair_count;

  int n_tests = 0;
  int n_fail  = 0;

  module_demux_12_seq #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sel_mode   (sel_mode),
    .sel        (sel),
    .out_1      (out_1),
    .out_2      (out_2),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .pair_count (pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic m, input logic s, input logic [WIDTH-1:0] d);
    sel_mode = m;
    sel      = s;
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic ack();
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'hA;
    sel_mode = 1'b0;
    sel      = 1'b0;
    out_ack  = 1'b0;
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_1", out_1, 0);
    check("rst_out_2", out_2, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", pair_count, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1);

    // Alternate mode pair
    beat(1'b0, 1'b0, 4'b0101);
    check("alt_b1_out_1", out_1, 4'b0101);
    check("alt_b1_valid", out_valid, 0);
    beat(1'b0, 1'b0, 4'b1110);
    check("alt_out_1", out_1, 4'b0101);
    check("alt_out_2", out_2, 4'b1110);
    check("alt_valid", out_valid, 1);
    in_valid = 1'b1;
    in_data  = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      check("hold_in_ready", in_ready, 0);
      step();
      check("hold_out_1", out_1, 4'b0101);
      check("hold_out_2", out_2, 4'b1110);
      check("hold_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    ack();
    check("alt_ack_valid", out_valid, 0);
    check("alt_ack_count", pair_count, 1);
    check("alt_ack_out_1_held", out_1, 4'b0101);

    // Explicit mode with overwrite of slot 2
    beat(1'b1, 1'b1, 4'b0011);
    check("sel_b1_out_2", out_2, 4'b0011);
    check("sel_b1_valid", out_valid, 0);
    beat(1'b1, 1'b1, 4'b1001);
    check("sel_b2_out_2", out_2, 4'b1001);
    check("sel_b2_valid", out_valid, 0);
    beat(1'b1, 1'b0, 4'b0110);
    check("sel_out_1", out_1, 4'b0110);
    check("sel_out_2", out_2, 4'b1001);
    check("sel_valid", out_valid, 1);
    ack();
    check("sel_count", pair_count, 2);

    // Mode change mid-pair is ignored
    beat(1'b0, 1'b0, 4'b0101);
    beat(1'b1, 1'b0, 4'b1110);
    check("modechg_out_1", out_1, 4'b0101);
    check("modechg_out_2", out_2, 4'b1110);
    check("modechg_valid", out_valid, 1);
    ack();
    check("modechg_count", pair_count, 3);

    // Ack outside FULL is ignored
    ack();
    check("stray_ack_count", pair_count, 3);
    check("stray_ack_valid", out_valid, 0);

    // Simultaneous ack and valid in FULL
    beat(1'b0, 1'b0, 4'b0001);
    beat(1'b0, 1'b0, 4'b0010);
    out_ack  = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'b1111;
    sel_mode = 1'b0;
    #1;
    check("simul_in_ready", in_ready, 0);
    step();
    out_ack = 1'b0;
    check("simul_out_1_kept", out_1, 4'b0001);
    check("simul_valid", out_valid, 0);
    check("simul_count", pair_count, 4);
    step();
    in_valid = 1'b0;
    check("simul_next_out_1", out_1, 4'b1111);
    check("simul_next_count", pair_count, 4);
    check("simul_next_valid", out_valid, 0);
    beat(1'b0, 1'b0, 4'b0000);
    check("simul_pair_valid", out_valid, 1);
    ack();
    check("simul_pair_count", pair_count, 5);

    // Reset in PART discards partial data
    beat(1'b0, 1'b0, 4'b0101);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstpart_out_1", out_1, 0);
    check("rstpart_valid", out_valid, 0);
    check("rstpart_count", pair_count, 0);
    beat(1'b0, 1'b0, 4'b0111);
    check("rstpart_empty_out_1", out_1, 4'b0111);
    check("rstpart_empty_valid", out_valid, 0);
    beat(1'b0, 1'b0, 4'b1000);
    check("rstpart_pair_valid", out_valid, 1);
    ack();
    check("rstpart_pair_count", pair_count, 1);

    // Counter wrap: 255 more acked pairs take it from 1 through 255 to 0
    for (int i = 0; i < 254; i++) begin
      beat(1'b0, 1'b0, 4'(i));
      beat(1'b0, 1'b0, 4'(i + 1));
      ack();
    end
    check("wrap_count_255", pair_count, 255);
    beat(1'b0, 1'b0, 4'h3);
    beat(1'b0, 1'b0, 4'hC);
    ack();
    check("wrap_count_0", pair_count, 0);
    check("wrap_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
